piso_serial_tx: RTL and testbench
=================================

// Module: piso_serial_tx
// PURPOSE
//  Parallel-in/serial-out transmitter: the read-out side of the enabled D-register banks.
//  Captures a WIDTH-bit word on a start request and shifts it out on one line as a frame.
//  Frame order: start bit (0), data LSB first, optional even-parity bit, stop bit (1).
//  One bit is sent per enable tick. Sits between a register bank and a serial pin or LED.
// PARAMETERS
//  WIDTH      4   data bits per frame (legal range 2..16)
//  PARITY_EN  1   1 = insert even-parity bit after the data bits; 0 = no parity bit
// PORTS
//  clk    in   1      rising-edge clock
//  rst    in   1      asynchronous, active-high reset
//  enable in   1      bit-rate tick; the FSM advances only on edges where enable=1
//  start  in   1      frame request; sampled every clk edge while idle, independent of enable
//  d      in   WIDTH  parallel data; captured on the edge that accepts start
//  sout   out  1      serial line; idles high
//  busy   out  1      high from the accept edge until the stop bit completes
//  done   out  1      one-clk pulse after the stop bit completes
// BEHAVIOUR
//  - Reset (asynchronous): sout=1, busy=0, done=0, state=IDLE, shift register=0, bit count=0.
//  - States: IDLE -> START -> DATA -> PARITY (only when PARITY_EN=1) -> STOP -> IDLE.
//  - IDLE: sout=1. When start=1 on an edge, load d into the shift register and compute
//    parity = ^d. On that same edge: go to START, set busy=1, set sout=0.
//  - START -> DATA: on the next enable tick, sout=sreg[0] and count=0.
//  - DATA: each enable tick shifts the register right and drives the next bit.
//    After WIDTH data bits, go to PARITY (sout=parity) or to STOP (sout=1).
//  - PARITY -> STOP: on an enable tick, sout=1.
//  - STOP -> IDLE: on an enable tick, busy=0 and done=1 for exactly one clk.
//  - Frame length: (WIDTH + 2 + PARITY_EN) enable ticks. The first bit time starts at the accept edge.
//  - enable=0: all state, sout and the count hold. done is still a single-clk pulse.
//  - start while busy: ignored, with no queuing. d changes while busy: no effect on the frame.
//  - start=1 in the same cycle done=1: accepted, giving back-to-back frames with no idle bit.
//  - Reset mid-frame: the line returns high immediately, with no partial stop bit and no done.
//  - Bit counter width: $clog2(WIDTH+1). It wraps only through the reload in IDLE, never free-running.
//  - All outputs come directly from registers; there is no combinational path from inputs to outputs.
// STRUCTURE
//  - Shared package piso_pkg: state encoding localparams S_IDLE=0, S_START=1, S_DATA=2,
//    S_PARITY=3, S_STOP=4 (3-bit state), plus the constants LINE_IDLE=1'b1 and START_BIT=1'b0.
//  - Sub-module piso_shreg (WIDTH): parallel load and shift-right-with-enable register, async
//    reset. Ports: clk, rst, load, shift, d, q0 (LSB).
//  - Top level: FSM, bit counter, parity register, output registers for sout, busy and done.
// TESTING (WIDTH=4, PARITY_EN=1 unless noted)
//  1. Reset asserted -> sout=1, busy=0, done=0. Release reset, enable=1, no start
//     -> sout stays 1 for 20 cycles.
//  2. enable=1, d=4'b1011, start pulse for 1 clk -> sout=0,1,1,0,1,1(parity),1 on successive
//     cycles; busy high for 7 cycles; done high on the 8th cycle only.
//  3. enable high 1 clk in 4, d=4'h6 -> each bit held 4 clks; sequence 0,0,1,1,0,0(parity),1;
//     done width = 1 clk.
//  4. Start pulsed again mid-frame with d=4'hF -> current frame is unchanged and no second frame
//     follows. Start held high through done -> second frame begins with no idle gap.
//  5. rst pulsed during the DATA bit for d[2] -> sout=1 and busy=0 asynchronously; done never
//     pulses. Next start sends a full clean frame.
//  6. PARITY_EN=0, WIDTH=8, d=8'hA5 -> 10-bit frame 0,1,0,1,0,0,1,0,1,1; done after the 10th bit.

Source files
------------

// File: rtl/piso_pkg.sv
// piso_pkg: state encoding and line constants shared by the serial transmitter files
package piso_pkg;
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_START  = 3'd1;
    localparam state_t S_DATA   = 3'd2;
    localparam state_t S_PARITY = 3'd3;
    localparam state_t S_STOP   = 3'd4;
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    function automatic logic even_parity(input logic [15:0] v);
        return ^v;
    endfunction
endpackage

// File: rtl/piso_serial_tx_if.sv
// piso_serial_tx_if: parallel request side and serial/status side of the transmitter
interface piso_serial_tx_if #(parameter int WIDTH = 4);
    logic enable;
    logic start;
    logic [WIDTH-1:0] d;
    logic sout;
    logic busy;
    logic done;
    modport master (output enable, start, d, input sout, busy, done);
    modport slave (input enable, start, d, output sout, busy, done);
endinterface

// File: rtl/piso_shreg.sv
// piso_shreg: parallel-load, shift-right-with-enable register exposing its LSB
module piso_shreg #(parameter int WIDTH = 4) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q0
);
    logic [WIDTH-1:0] q;
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else if (load) q <= d;
        else if (shift) q <= {1'b0, q[WIDTH-1:1]};
    assign q0 = q[0];
endmodule

// File: rtl/piso_serial_tx.sv
// piso_serial_tx: frames a captured word as start, LSB-first data, optional even parity, stop
module piso_serial_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1
) (
    input logic              clk,
    input logic              rst,
    piso_serial_tx_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic par, par_n, sout, sout_n, busy, busy_n, done, done_n, load, shift, q0;
    piso_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk(clk), .rst(rst), .load(load), .shift(shift), .d(bus.d), .q0(q0)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            par   <= 1'b0;
            sout  <= LINE_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            par   <= par_n;
            sout  <= sout_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   state_n = bus.start ? S_START : S_IDLE;
            S_START:  state_n = bus.enable ? S_DATA : S_START;
            S_DATA:   state_n = (bus.enable && cnt == LAST) ? (PARITY_EN ? S_PARITY : S_STOP) : S_DATA;
            S_PARITY: state_n = bus.enable ? S_STOP : S_PARITY;
            S_STOP:   state_n = bus.enable ? S_IDLE : S_STOP;
            default:  state_n = S_IDLE;
        endcase
    end
    // The register is shifted as each bit is launched, so q0 always holds the next data bit.
    always_comb begin
        sout_n = sout;
        busy_n = busy;
        done_n = 1'b0;
        cnt_n  = cnt;
        par_n  = par;
        load   = 1'b0;
        shift  = 1'b0;
        case (state)
            S_IDLE: begin
                load   = bus.start;
                sout_n = bus.start ? START_BIT : LINE_IDLE;
                busy_n = bus.start;
                par_n  = bus.start ? even_parity(16'(bus.d)) : par;
                cnt_n  = '0;
            end
            S_START: if (bus.enable) begin
                sout_n = q0;
                shift  = 1'b1;
                cnt_n  = '0;
            end
            S_DATA: if (bus.enable) begin
                shift  = cnt != LAST;
                sout_n = (cnt != LAST) ? q0 : (PARITY_EN ? par : LINE_IDLE);
                cnt_n  = (cnt != LAST) ? cnt + 1'b1 : cnt;
            end
            S_PARITY: if (bus.enable) sout_n = LINE_IDLE;
            S_STOP: if (bus.enable) begin
                busy_n = 1'b0;
                done_n = 1'b1;
            end
            default: begin
                sout_n = LINE_IDLE;
                busy_n = 1'b0;
            end
        endcase
    end
    assign bus.sout = sout;
    assign bus.busy = busy;
    assign bus.done = done;
endmodule

// File: tb/tb_piso_serial_tx.sv
// tb_piso_serial_tx: directed frames with a queue scoreboard checking every launched bit and frame length
module tb_piso_serial_tx;
    logic clk, rst;
    int checks = 0, errors = 0;
    piso_serial_tx_if #(.WIDTH(4)) b0 ();
    piso_serial_tx_if #(.WIDTH(8)) b1 ();
    piso_serial_tx #(.WIDTH(4), .PARITY_EN(1)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    piso_serial_tx #(.WIDTH(8), .PARITY_EN(0)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    initial clk = 0;
    always #5 clk = ~clk;
    bit exp_q[2][$];
    int len_q[2][$];
    wire [1:0] so = {b1.sout, b0.sout};
    wire [1:0] bs = {b1.busy, b0.busy};
    wire [1:0] dn = {b1.done, b0.done};
    wire [1:0] en = {b1.enable, b0.enable};
    logic [1:0] en_edge = '0, busy_p = '0, done_p = '0, sout_p = '1;
    int nb[2];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask
    task automatic push(input int c, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) exp_q[c].push_back(bits[i]);
        len_q[c].push_back(n);
    endtask
    always @(posedge clk) en_edge <= en;
    // A new bit starts on the accept edge or on any enable tick while busy.
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                busy_p[c] = 1'b0;
                done_p[c] = 1'b0;
                nb[c] = 0;
            end else begin
                if (bs[c] && (!busy_p[c] || en_edge[c])) begin
                    check($sformatf("ch%0d_bit_expected", c), exp_q[c].size() > 0, 1);
                    if (exp_q[c].size() > 0)
                        check($sformatf("ch%0d_bit%0d", c, nb[c]), so[c], exp_q[c].pop_front());
                    nb[c]++;
                end else if (bs[c]) check($sformatf("ch%0d_hold", c), so[c], sout_p[c]);
                if (dn[c]) begin
                    check($sformatf("ch%0d_done_single", c), done_p[c], 0);
                    check($sformatf("ch%0d_done_not_busy", c), bs[c], 0);
                    check($sformatf("ch%0d_done_expected", c), len_q[c].size() > 0, 1);
                    if (len_q[c].size() > 0)
                        check($sformatf("ch%0d_frame_len", c), nb[c], len_q[c].pop_front());
                    nb[c] = 0;
                end
                busy_p[c] = bs[c];
                done_p[c] = dn[c];
                sout_p[c] = so[c];
            end
        end
    end
    task automatic wait_done(input int per, input int glitch, output int bc, output bit seen);
        bc = 0;
        seen = 0;
        for (int k = 1; k < 200 && !seen; k++) begin
            if (b0.done) seen = 1;
            else begin
                bc += int'(b0.busy);
                b0.enable = (k % per == 0);
                if (glitch >= 0) b0.start = (k == glitch);
                if (k == glitch) b0.d = 4'hF;
                @(negedge clk);
            end
        end
        b0.enable = 1'b1;
    endtask
    task automatic send(input logic [3:0] dv, input int per, input int glitch, output int bc);
        bit seen;
        b0.d = dv;
        b0.start = 1'b1;
        b0.enable = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        wait_done(per, glitch, bc, seen);
        check("done_seen", seen, 1);
        b0.start = 1'b0;
        @(negedge clk);
        check("done_width", b0.done, 0);
    endtask
    initial begin
        int bc;
        bit seen;
        rst = 1'b1;
        b0.enable = 1'b0;
        b0.start = 1'b0;
        b0.d = '0;
        b1.enable = 1'b1;
        b1.start = 1'b0;
        b1.d = '0;
        #3;
        check("rst_sout", b0.sout, 1);
        check("rst_busy", b0.busy, 0);
        check("rst_done", b0.done, 0);
        check("rst_sout_w8", b1.sout, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        b0.enable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("idle_sout", b0.sout, 1);
            check("idle_busy", b0.busy, 0);
        end
        push(0, 16'b1110110, 7);
        send(4'b1011, 1, 0, bc);
        check("busy_cycles_1011", bc, 7);
        push(0, 16'b1001100, 7);
        send(4'h6, 4, 0, bc);
        check("busy_cycles_slow", bc, 28);
        push(0, 16'b1001100, 7);
        send(4'h6, 1, 3, bc);
        check("busy_cycles_glitch", bc, 7);
        repeat (8) begin
            @(negedge clk);
            check("no_queued_frame", b0.busy, 0);
        end
        push(0, 16'b1011110, 7);
        push(0, 16'b1011110, 7);
        b0.d = 4'hF;
        b0.start = 1'b1;
        @(negedge clk);
        wait_done(1, -1, bc, seen);
        check("b2b_first_done", seen, 1);
        check("b2b_first_busy", bc, 7);
        @(negedge clk);
        check("b2b_start_bit", b0.sout, 0);
        check("b2b_busy", b0.busy, 1);
        b0.start = 1'b0;
        wait_done(1, 0, bc, seen);
        check("b2b_second_done", seen, 1);
        check("b2b_second_busy", bc, 7);
        @(negedge clk);
        push(0, 16'b1001010, 7);
        b0.d = 4'b0101;
        b0.start = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_sout", b0.sout, 1);
        check("midrst_busy", b0.busy, 0);
        @(negedge clk);
        #1;
        exp_q[0].delete();
        len_q[0].delete();
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("midrst_no_done", b0.done, 0);
            check("midrst_line_high", b0.sout, 1);
        end
        push(0, 16'b1000110, 7);
        send(4'h3, 1, 0, bc);
        check("busy_cycles_after_rst", bc, 7);
        push(1, 16'b1101001010, 10);
        b1.d = 8'hA5;
        b1.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        bc = 0;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (b1.done) seen = 1;
            else begin
                bc += int'(b1.busy);
                @(negedge clk);
            end
        end
        check("w8_done_seen", seen, 1);
        check("w8_busy_cycles", bc, 10);
        repeat (2) @(negedge clk);
        check("ch0_bits_left", exp_q[0].size(), 0);
        check("ch0_frames_left", len_q[0].size(), 0);
        check("ch1_bits_left", exp_q[1].size(), 0);
        check("ch1_frames_left", len_q[1].size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
